// File: rtl/eggtimer_pkg.sv
// Shared types and constants for the egg timer control path.
// Imported by the entry register and the control FSM.
package eggtimer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_TENS_SEC = 4'd5;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_ALARM = 3'd5
    } state_t;

endpackage

// File: rtl/bcd_entry_reg.sv
// Four-digit BCD shift register for keypad entry of an mm:ss setting.
// New digits enter at the seconds position; the tens-of-minutes digit drops out.
module bcd_entry_reg
    import eggtimer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               shift,
    input  logic               clear,
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] s,
    output logic [DIGIT_W-1:0] ts,
    output logic [DIGIT_W-1:0] m,
    output logic [DIGIT_W-1:0] tm,
    output logic               all_zero,
    output logic               valid
);

    logic [4*DIGIT_W-1:0] r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r <= '0;
        end else if (clear) begin
            r <= '0;
        end else if (shift) begin
            r <= {r[3*DIGIT_W-1:0], digit};
        end
    end

    assign s  = r[DIGIT_W-1:0];
    assign ts = r[2*DIGIT_W-1:DIGIT_W];
    assign m  = r[3*DIGIT_W-1:2*DIGIT_W];
    assign tm = r[4*DIGIT_W-1:3*DIGIT_W];

    assign all_zero = (r == '0);
    assign valid    = (ts <= MAX_TENS_SEC);

endmodule

// File: rtl/eggtimer_ctrl.sv
// Egg timer control FSM: keypad entry, load/run/pause of time_count,
// countdown expiry detection and a timed alarm.
module eggtimer_ctrl
    import eggtimer_pkg::*;
#(
    parameter int unsigned ALARM_SECS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse_1s,
    input  logic       key_strobe,
    input  logic [3:0] key_val,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic [3:0] seconds,
    input  logic [3:0] tens_seconds,
    input  logic [3:0] minutes,
    input  logic [3:0] tens_minutes,
    output logic [3:0] seconds_prog,
    output logic [3:0] tens_seconds_prog,
    output logic [3:0] minutes_prog,
    output logic [3:0] tens_minutes_prog,
    output logic       load,
    output logic       timer_on,
    output logic       alarm,
    output logic       entry_err,
    output logic [2:0] state_o
);

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] acnt;
    logic [3:0] acnt_n;
    logic       shift;
    logic       clr;
    logic       err_n;
    logic       all_zero;
    logic       valid;
    logic       key_ok;
    logic       expired;

    bcd_entry_reg u_entry (
        .clk      (clk),
        .reset    (reset),
        .shift    (shift),
        .clear    (clr),
        .digit    (key_val),
        .s        (seconds_prog),
        .ts       (tens_seconds_prog),
        .m        (minutes_prog),
        .tm       (tens_minutes_prog),
        .all_zero (all_zero),
        .valid    (valid)
    );

    assign key_ok  = key_strobe && (key_val <= MAX_DIGIT);
    assign expired = (seconds == 4'd0) && (tens_seconds == 4'd0) &&
                     (minutes == 4'd0) && (tens_minutes == 4'd0);

    always_comb begin
        state_n = state;
        acnt_n  = 4'd0;
        shift   = 1'b0;
        clr     = 1'b0;
        err_n   = 1'b0;
        if (btn_clear) begin
            state_n = S_IDLE;
            clr     = 1'b1;
        end else begin
            unique case (state)
                S_IDLE, S_ENTRY: begin
                    if (btn_start) begin
                        if (!all_zero && valid) state_n = S_LOAD;
                        else                    err_n   = 1'b1;
                    end else if (key_ok) begin
                        shift   = 1'b1;
                        state_n = S_ENTRY;
                    end
                end
                S_LOAD: state_n = S_RUN;
                S_RUN: begin
                    if (btn_stop)     state_n = S_PAUSE;
                    else if (expired) state_n = S_ALARM;
                end
                S_PAUSE: begin
                    if (btn_stop) begin
                        state_n = S_IDLE;
                        clr     = 1'b1;
                    end else if (btn_start) begin
                        state_n = S_RUN;
                    end
                end
                S_ALARM: begin
                    // Any user action silences the buzzer; keys are not captured.
                    if (btn_stop || btn_start || key_ok) begin
                        state_n = S_IDLE;
                    end else if (pulse_1s) begin
                        if (acnt == ALARM_LAST) state_n = S_IDLE;
                        else                    acnt_n  = acnt + 4'd1;
                    end else begin
                        acnt_n = acnt;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            acnt      <= 4'd0;
            load      <= 1'b0;
            timer_on  <= 1'b0;
            alarm     <= 1'b0;
            entry_err <= 1'b0;
        end else begin
            state     <= state_n;
            acnt      <= acnt_n;
            load      <= (state_n == S_LOAD);
            timer_on  <= (state_n == S_RUN);
            alarm     <= (state_n == S_ALARM);
            entry_err <= err_n;
        end
    end

    assign state_o = state;

endmodule
